// File: rtl/banked_main_mem.sv
// Four-bank word-interleaved main memory with per-bank occupancy counters
// and a fixed two-stage read return pipeline.
module banked_main_mem #(
  parameter int unsigned MEM_AW   = 15,
  parameter int unsigned BANK_CYC = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  input  logic        wr,
  input  logic        rd,
  output logic [15:0] data_out,
  output logic [3:0]  busy,
  output logic        stall,
  output logic        err
);

  localparam int unsigned DW    = 16;
  localparam int unsigned NB    = 4;
  localparam int unsigned CW    = $clog2(BANK_CYC);
  localparam int unsigned DEPTH = 1 << MEM_AW;
  localparam logic [CW-1:0] CNT_LOAD = CW'(BANK_CYC - 1);

  logic [DW-1:0] mem [DEPTH];

  logic [NB-1:0][CW-1:0] cnt_q, cnt_d;
  logic                  v1_q, v1_d;
  logic                  v2_q, v2_d;
  logic [DW-1:0]         d1_q, d1_d;
  logic [DW-1:0]         d2_q, d2_d;

  logic              req;
  logic              acc;
  logic [1:0]        bank;
  logic [MEM_AW-1:0] widx;

  assign bank = addr[2:1];
  assign widx = addr[MEM_AW:1];

  // Occupancy decode from the per-bank counters
  always_comb begin
    busy = '0;
    for (int unsigned b = 0; b < NB; b++) begin
      busy[b] = (cnt_q[b] != '0);
    end
  end

  // Request classification: illegal requests win over bank conflicts
  always_comb begin
    req   = rd | wr;
    err   = (rd & wr) | (req & addr[0]);
    stall = req & ~err & busy[bank];
    acc   = req & ~err & ~busy[bank];
  end

  always_comb begin
    cnt_d = cnt_q;
    for (int unsigned b = 0; b < NB; b++) begin
      if (acc && (bank == 2'(b))) begin
        cnt_d[b] = CNT_LOAD;
      end else if (cnt_q[b] != '0) begin
        cnt_d[b] = cnt_q[b] - CW'(1);
      end
    end
  end

  // Read return pipeline; stage 1 holds its data when no read is accepted
  always_comb begin
    v1_d = acc & rd;
    d1_d = d1_q;
    if (acc && rd) begin
      d1_d = mem[widx];
    end
    v2_d = v1_q;
    d2_d = d1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      d1_q  <= '0;
      d2_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      v1_q  <= v1_d;
      v2_q  <= v2_d;
      d1_q  <= d1_d;
      d2_q  <= d2_d;
    end
  end

  // Array has no reset so contents survive a reset pulse
  always_ff @(posedge clk) begin
    if (acc && wr) begin
      mem[widx] <= data_in;
    end
  end

  assign data_out = v2_q ? d2_q : '0;

endmodule

// File: tb/tb_banked_main_mem.sv
// Randomized scoreboard bench for banked_main_mem against a cycle-count
// reference model of bank occupancy and read latency.
module tb_banked_main_mem;

  localparam int unsigned BANK_CYC = 4;
  localparam int          NWORDS   = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic        wr;
  logic        rd;
  logic [15:0] data_out;
  logic [3:0]  busy;
  logic        stall;
  logic        err;

  banked_main_mem #(.MEM_AW(15), .BANK_CYC(BANK_CYC)) dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .data_in  (data_in),
    .wr       (wr),
    .rd       (rd),
    .data_out (data_out),
    .busy     (busy),
    .stall    (stall),
    .err      (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    int          due;
  } ret_t;

  int          cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  int          acc_cyc [4];
  logic [15:0] ref_mem [NWORDS];
  ret_t        sb_q [$];
  logic        exp_stall = 1'b0;
  logic        exp_err = 1'b0;
  logic        mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
  endtask

  function automatic bit bank_busy(input int b);
    return (cyc > acc_cyc[b]) && (cyc < acc_cyc[b] + int'(BANK_CYC));
  endfunction

  // Monitor: compares every cycle's outputs against the model
  always @(negedge clk) begin : monitor
    logic [3:0]  eb;
    logic [15:0] ed;
    if (mon_en) begin
      for (int b = 0; b < 4; b++) eb[b] = bank_busy(b);
      ed = '0;
      if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
        ed = sb_q[0].data;
        void'(sb_q.pop_front());
      end
      check("busy", 32'(busy), 32'(eb));
      check("stall", 32'(stall), 32'(exp_stall));
      check("err", 32'(err), 32'(exp_err));
      check("data_out", 32'(data_out), 32'(ed));
    end
  end

  task automatic issue(input logic r, input logic w, input logic [15:0] a,
                       input logic [15:0] d, output logic accepted);
    int b;
    bit bsy;
    ret_t e;
    b = int'(a[2:1]);
    rd = r; wr = w; addr = a; data_in = d;
    bsy = bank_busy(b);
    exp_err   = (r && w) || ((r || w) && a[0]);
    exp_stall = (r || w) && !exp_err && bsy;
    accepted  = (r || w) && !exp_err && !bsy;
    if (accepted) begin
      acc_cyc[b] = cyc;
      if (w) begin
        ref_mem[a[5:1]] = d;
      end else begin
        e.data = ref_mem[a[5:1]];
        e.due  = cyc + 2;
        sb_q.push_back(e);
      end
    end
    @(posedge clk); #1;
    rd = 1'b0; wr = 1'b0; exp_err = 1'b0; exp_stall = 1'b0;
  endtask

  task automatic issue_until(input logic r, input logic w, input logic [15:0] a,
                             input logic [15:0] d);
    logic ok;
    ok = 1'b0;
    for (int t = 0; t < 20 && !ok; t++) issue(r, w, a, d, ok);
    if (!ok) check("accept_timeout", 32'(ok), 32'd1);
  endtask

  task automatic idle(input int n);
    rd = 1'b0; wr = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic ok;
    int   op;
    int   idx;
    rd = 1'b0; wr = 1'b0; addr = '0; data_in = '0; rst = 1'b1;
    for (int b = 0; b < 4; b++) acc_cyc[b] = -100;
    mon_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < NWORDS; i++)
      issue_until(1'b0, 1'b1, 16'(i * 2), 16'($urandom));
    idle(4);

    // Write then read the same word while its bank is still occupied
    issue(1'b0, 1'b1, 16'h0010, 16'hBEEF, ok);
    issue_until(1'b1, 1'b0, 16'h0010, 16'h0);
    idle(4);

    // Interleaved burst across all four banks
    issue_until(1'b0, 1'b1, 16'h0000, 16'h1111);
    issue_until(1'b0, 1'b1, 16'h0002, 16'h2222);
    issue_until(1'b0, 1'b1, 16'h0004, 16'h3333);
    issue_until(1'b0, 1'b1, 16'h0006, 16'h4444);
    idle(4);
    for (int i = 0; i < 4; i++) issue(1'b1, 1'b0, 16'(i * 2), 16'h0, ok);
    idle(4);

    // Same-bank conflict
    issue(1'b1, 1'b0, 16'h0008, 16'h0, ok);
    issue_until(1'b1, 1'b0, 16'h0018, 16'h0);
    idle(4);

    // Illegal requests leave array and banks untouched
    issue(1'b1, 1'b0, 16'h0003, 16'h0, ok);
    issue(1'b1, 1'b1, 16'h0020, 16'hDEAD, ok);
    issue_until(1'b1, 1'b0, 16'h0020, 16'h0);
    idle(4);

    // Asynchronous reset in the middle of a pending read
    issue(1'b1, 1'b0, 16'h000A, 16'h0, ok);
    #1 rst = 1'b1;
    #1 check("busy_async_rst", 32'(busy), 32'd0);
    sb_q.delete();
    for (int b = 0; b < 4; b++) acc_cyc[b] = -100;
    #1 rst = 1'b0;
    @(posedge clk); #1;
    idle(2);
    issue_until(1'b1, 1'b0, 16'h0010, 16'h0);
    idle(4);

    for (int i = 0; i < 600; i++) begin
      op  = int'($urandom_range(0, 9));
      idx = int'($urandom_range(0, NWORDS - 1));
      case (op)
        0, 1:       idle(1);
        2, 3, 4, 5: issue(1'b1, 1'b0, 16'(idx * 2), 16'h0, ok);
        6, 7, 8:    issue(1'b0, 1'b1, 16'(idx * 2), 16'($urandom), ok);
        default: begin
          if ($urandom_range(0, 1) == 0)
            issue(1'b1, 1'b1, 16'(idx * 2), 16'($urandom), ok);
          else
            issue(1'($urandom_range(0, 1)), 1'b1, 16'(idx * 2 + 1), 16'($urandom), ok);
        end
      endcase
    end
    idle(6);
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
